// File: rtl/show_string_pkg.sv
// Shared font geometry, blank glyph code and controller state encoding
// for the multi-line string drawing controller.
package show_string_pkg;

    localparam int CHAR_W16 = 8;
    localparam int CHAR_H16 = 16;
    localparam int CHAR_W12 = 6;
    localparam int CHAR_H12 = 12;

    localparam logic [6:0] GLYPH_BLANK = 7'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_ISSUE,
        ST_WAIT,
        ST_FIN
    } state_t;

endpackage

// File: rtl/string_char_ram.sv
// Simple dual-port glyph buffer: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old data.
module string_char_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [6:0]    rd_data
);

    logic [6:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/show_string_multi_ctrl.sv
// Draws the glyph buffer as a wrapped text block, one char per renderer handshake.
// refresh -> first flag 3 cycles; done -> next flag 3 cycles; frame_done one cycle after last done.
module show_string_multi_ctrl
    import show_string_pkg::*;
#(
    parameter int MAX_CHARS  = 32,
    parameter int LINE_CHARS = 12,
    parameter int FONT16     = 1,
    parameter int ORIGIN_X   = 128,
    parameter int ORIGIN_Y   = 16,
    parameter int COORD_W    = 9
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         init_done,
    input  logic                         show_char_done,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_CHARS)-1:0] wr_addr,
    input  logic [6:0]                   wr_data,
    input  logic [$clog2(MAX_CHARS):0]   str_len,
    input  logic                         refresh,
    output logic                         en_size,
    output logic                         show_char_flag,
    output logic [6:0]                   ascii_num,
    output logic [COORD_W-1:0]           start_x,
    output logic [COORD_W-1:0]           start_y,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int AW = $clog2(MAX_CHARS);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(LINE_CHARS + 1);

    localparam logic [COORD_W-1:0] STEP_X   = COORD_W'(FONT16 != 0 ? CHAR_W16 : CHAR_W12);
    localparam logic [COORD_W-1:0] STEP_Y   = COORD_W'(FONT16 != 0 ? CHAR_H16 : CHAR_H12);
    localparam logic [COORD_W-1:0] X0       = COORD_W'(ORIGIN_X);
    localparam logic [COORD_W-1:0] Y0       = COORD_W'(ORIGIN_Y);
    localparam logic [CW-1:0]      COL_LAST = CW'(LINE_CHARS - 1);
    localparam logic [LW-1:0]      LEN_MAX  = LW'(MAX_CHARS);

    state_t             state;
    state_t             state_nxt;
    logic [LW-1:0]      len;
    logic [LW-1:0]      len_clamped;
    logic [AW-1:0]      idx;
    logic [CW-1:0]      col;
    logic [COORD_W-1:0] x_pos;
    logic [COORD_W-1:0] y_pos;
    logic               pending;
    logic [6:0]         rd_data;
    logic               start_frame;
    logic               last_char;
    logic               char_done;

    string_char_ram #(
        .DEPTH (MAX_CHARS),
        .AW    (AW)
    ) u_ram (
        .clk     (sys_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

    assign en_size     = (FONT16 != 0);
    assign busy        = (state != ST_IDLE);
    assign frame_done  = (state == ST_FIN);
    assign len_clamped = (str_len > LEN_MAX) ? LEN_MAX : str_len;
    assign start_frame = (state == ST_IDLE) && init_done && (refresh || pending);
    assign last_char   = ({1'b0, idx} == len - LW'(1));
    assign char_done   = (state == ST_WAIT) && show_char_done;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_frame) state_nxt = (len_clamped == '0) ? ST_FIN : ST_RD;
            ST_RD:    state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (char_done) state_nxt = last_char ? ST_FIN : ST_RD;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Losing the LCD mid-frame abandons the frame silently.
        if (state != ST_IDLE && !init_done) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state          <= ST_IDLE;
            len            <= '0;
            idx            <= '0;
            col            <= '0;
            x_pos          <= '0;
            y_pos          <= '0;
            pending        <= 1'b0;
            show_char_flag <= 1'b0;
            ascii_num      <= GLYPH_BLANK;
            start_x        <= '0;
            start_y        <= '0;
        end else begin
            state          <= state_nxt;
            show_char_flag <= (state == ST_ISSUE) && init_done;

            if (!init_done || start_frame) begin
                pending <= 1'b0;
            end else if (busy && refresh) begin
                pending <= 1'b1;
            end

            if (start_frame) begin
                len   <= len_clamped;
                idx   <= '0;
                col   <= '0;
                x_pos <= X0;
                y_pos <= Y0;
            end

            if (state == ST_ISSUE) begin
                ascii_num <= rd_data;
                start_x   <= x_pos;
                start_y   <= y_pos;
            end

            // Position advances by adding the glyph pitch; wrap restarts x and steps y.
            if (char_done && init_done && !last_char) begin
                idx <= idx + AW'(1);
                if (col == COL_LAST) begin
                    col   <= '0;
                    x_pos <= X0;
                    y_pos <= y_pos + STEP_Y;
                end else begin
                    col   <= col + CW'(1);
                    x_pos <= x_pos + STEP_X;
                end
            end
        end
    end

endmodule

// File: tb/tb_show_string_multi_ctrl.sv
// Three controller instances (default, 4-char lines, 12x6 font) share stimulus;
// an event-scheduling model predicts flags, coordinates, busy and frame_done per cycle.
module tb_show_string_multi_ctrl;

    localparam int LC  [3] = '{12, 4, 12};
    localparam int CWT [3] = '{8, 8, 6};
    localparam int CHT [3] = '{16, 16, 12};
    localparam int ENT [3] = '{1, 1, 0};

    logic       clk;
    logic       rst;
    logic       init_done;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [6:0] wr_data;
    logic [5:0] str_len;
    logic       refresh;
    logic       done   [3];
    logic       en_w   [3];
    logic       flag_w [3];
    logic       busy_w [3];
    logic       fd_w   [3];
    logic [6:0] asc_w  [3];
    logic [8:0] x_w    [3];
    logic [8:0] y_w    [3];

    int tests;
    int fails;
    int cyc;
    int dly;
    bit spur;

    bit         act   [3];
    bit         pend  [3];
    bit         wt    [3];
    int         nflag [3];
    int         fdone [3];
    int         flen  [3];
    int         nxt   [3];
    int         due   [3];
    logic [6:0] hc    [3];
    logic [8:0] hx    [3];
    logic [8:0] hy    [3];
    int         nfl   [3];
    int         nfd   [3];
    int         fd_cyc[3];
    logic [8:0] lx [3][256];
    logic [8:0] ly [3][256];
    logic [6:0] lc [3][256];
    logic [6:0] shadow [32];
    logic [6:0] hello [12];
    int         rcyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    show_string_multi_ctrl #(.MAX_CHARS(32), .LINE_CHARS(12), .FONT16(1),
        .ORIGIN_X(128), .ORIGIN_Y(16), .COORD_W(9)) dut0 (
        .sys_clk(clk), .sys_rst(rst), .init_done(init_done), .show_char_done(done[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .str_len(str_len),
        .refresh(refresh), .en_size(en_w[0]), .show_char_flag(flag_w[0]),
        .ascii_num(asc_w[0]), .start_x(x_w[0]), .start_y(y_w[0]),
        .busy(busy_w[0]), .frame_done(fd_w[0]));

    show_string_multi_ctrl #(.MAX_CHARS(32), .LINE_CHARS(4), .FONT16(1),
        .ORIGIN_X(128), .ORIGIN_Y(16), .COORD_W(9)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .init_done(init_done), .show_char_done(done[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .str_len(str_len),
        .refresh(refresh), .en_size(en_w[1]), .show_char_flag(flag_w[1]),
        .ascii_num(asc_w[1]), .start_x(x_w[1]), .start_y(y_w[1]),
        .busy(busy_w[1]), .frame_done(fd_w[1]));

    show_string_multi_ctrl #(.MAX_CHARS(32), .LINE_CHARS(12), .FONT16(0),
        .ORIGIN_X(128), .ORIGIN_Y(16), .COORD_W(9)) dut2 (
        .sys_clk(clk), .sys_rst(rst), .init_done(init_done), .show_char_done(done[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .str_len(str_len),
        .refresh(refresh), .en_size(en_w[2]), .show_char_flag(flag_w[2]),
        .ascii_num(asc_w[2]), .start_x(x_w[2]), .start_y(y_w[2]),
        .busy(busy_w[2]), .frame_done(fd_w[2]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
        end
    endtask

    // Evaluated once per cycle on the falling edge: compare, then schedule future events.
    task automatic model_eval();
        for (int d = 0; d < 3; d++) begin
            bit ef;
            bit ed;
            bit an;
            int i;
            if (rst) begin
                act[d] = 0; pend[d] = 0; wt[d] = 0;
                nflag[d] = -1; fdone[d] = -1; due[d] = -1;
                continue;
            end
            ef = (cyc == nflag[d]);
            ed = (cyc == fdone[d]);
            chk($sformatf("flag%0d", d), 32'(flag_w[d]), 32'(ef));
            chk($sformatf("frame_done%0d", d), 32'(fd_w[d]), 32'(ed));
            chk($sformatf("busy%0d", d), 32'(busy_w[d]), 32'(act[d]));
            if (fd_w[d] === 1'b1) begin
                nfd[d]++;
                fd_cyc[d] = cyc;
            end
            if (flag_w[d] === 1'b1) begin
                lx[d][nfl[d] % 256] = x_w[d];
                ly[d][nfl[d] % 256] = y_w[d];
                lc[d][nfl[d] % 256] = asc_w[d];
                nfl[d]++;
            end
            if (ef) begin
                i = nxt[d];
                hc[d] = shadow[i];
                hx[d] = 9'(128 + (i % LC[d]) * CWT[d]);
                hy[d] = 9'(16 + (i / LC[d]) * CHT[d]);
                nxt[d]++;
                wt[d] = 1;
                nflag[d] = -1;
                due[d] = cyc + dly;
            end
            if (wt[d]) begin
                chk($sformatf("ascii%0d", d), 32'(asc_w[d]), 32'(hc[d]));
                chk($sformatf("x%0d", d), 32'(x_w[d]), 32'(hx[d]));
                chk($sformatf("y%0d", d), 32'(y_w[d]), 32'(hy[d]));
            end
            an = act[d];
            if (ed) begin
                an = 0;
                fdone[d] = -1;
            end
            if (act[d] && !init_done) begin
                an = 0; pend[d] = 0; wt[d] = 0; nflag[d] = -1; fdone[d] = -1;
            end else if (act[d]) begin
                if (refresh) pend[d] = 1;
                if (wt[d] && done[d]) begin
                    wt[d] = 0;
                    if (nxt[d] == flen[d]) fdone[d] = cyc + 1;
                    else nflag[d] = cyc + 3;
                end
            end else if (!init_done) begin
                pend[d] = 0;
            end else if (refresh || pend[d]) begin
                pend[d] = 0;
                flen[d] = (str_len > 32) ? 32 : int'(str_len);
                nxt[d] = 0;
                an = 1;
                if (flen[d] == 0) fdone[d] = cyc + 1;
                else nflag[d] = cyc + 3;
            end
            act[d] = an;
        end
    endtask

    task automatic step();
        bit sp;
        @(negedge clk);
        model_eval();
        @(posedge clk);
        cyc++;
        #1;
        sp = spur && ($urandom_range(0, 15) == 0);
        for (int d = 0; d < 3; d++) done[d] = (cyc == due[d]) || sp;
    endtask

    function automatic bit any_busy();
        return act[0] || act[1] || act[2] || pend[0] || pend[1] || pend[2];
    endfunction

    task automatic wr(input int a, input logic [6:0] v);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = v;
        shadow[a] = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        rcyc = cyc;
        step();
        refresh = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int n = 0;
        while (any_busy() && n < bound) begin
            step();
            n++;
        end
        chk({nm, "_timeout"}, 32'(n >= bound), 32'd0);
    endtask

    task automatic wait_flags(input int want, input int base, input string nm);
        int n = 0;
        while ((nfl[0] - base) < want && n < 500) begin
            step();
            n++;
        end
        chk({nm, "_timeout"}, 32'(n >= 500), 32'd0);
    endtask

    initial begin
        int b0, b1, b2, f0;
        int t1x [12] = '{128, 136, 144, 152, 160, 168, 176, 184, 192, 200, 208, 216};
        int t2x [6]  = '{128, 136, 144, 152, 128, 136};
        int t2y [6]  = '{16, 16, 16, 16, 32, 32};
        int t3x [3]  = '{128, 134, 140};
        hello = '{7'd40, 7'd69, 7'd76, 7'd76, 7'd79, 7'd0, 7'd55, 7'd79, 7'd82, 7'd76, 7'd68, 7'd1};
        tests = 0; fails = 0; cyc = 0; dly = 5; spur = 0; rcyc = 0;
        rst = 1'b1; init_done = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        str_len = '0; refresh = 1'b0;
        for (int d = 0; d < 3; d++) begin
            done[d] = 1'b0; nfl[d] = 0; nfd[d] = 0; fd_cyc[d] = 0;
            act[d] = 0; pend[d] = 0; wt[d] = 0; nflag[d] = -1; fdone[d] = -1; due[d] = -1;
            flen[d] = 0; nxt[d] = 0;
        end
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            chk("rst_flag", 32'(flag_w[d]), 0);
            chk("rst_ascii", 32'(asc_w[d]), 0);
            chk("rst_x", 32'(x_w[d]), 0);
            chk("rst_y", 32'(y_w[d]), 0);
            chk("rst_busy", 32'(busy_w[d]), 0);
            chk("rst_frame_done", 32'(fd_w[d]), 0);
            chk("en_size", 32'(en_w[d]), 32'(ENT[d]));
        end
        rst = 1'b0; init_done = 1'b1;
        step();
        for (int i = 0; i < 12; i++) wr(i, hello[i]);
        for (int i = 12; i < 32; i++) wr(i, 7'($urandom_range(0, 94)));

        // Hello World on one row
        b0 = nfl[0]; f0 = nfd[0];
        str_len = 6'd12;
        pulse_refresh();
        wait_idle(500, "t1");
        chk("t1_flags", 32'(nfl[0] - b0), 12);
        for (int j = 0; j < 12; j++) begin
            chk("t1_x", 32'(lx[0][(b0 + j) % 256]), 32'(t1x[j]));
            chk("t1_y", 32'(ly[0][(b0 + j) % 256]), 16);
            chk("t1_code", 32'(lc[0][(b0 + j) % 256]), 32'(hello[j]));
        end
        chk("t1_frames", 32'(nfd[0] - f0), 1);
        chk("t1_busy_after", 32'(busy_w[0]), 0);

        // wrap at 4 chars per row
        b1 = nfl[1];
        str_len = 6'd6;
        pulse_refresh();
        wait_idle(500, "t2");
        chk("t2_flags", 32'(nfl[1] - b1), 6);
        for (int j = 0; j < 6; j++) begin
            chk("t2_x", 32'(lx[1][(b1 + j) % 256]), 32'(t2x[j]));
            chk("t2_y", 32'(ly[1][(b1 + j) % 256]), 32'(t2y[j]));
        end

        // 12x6 font pitch
        b2 = nfl[2];
        str_len = 6'd3;
        pulse_refresh();
        wait_idle(500, "t3");
        chk("t3_flags", 32'(nfl[2] - b2), 3);
        for (int j = 0; j < 3; j++) begin
            chk("t3_x", 32'(lx[2][(b2 + j) % 256]), 32'(t3x[j]));
            chk("t3_y", 32'(ly[2][(b2 + j) % 256]), 16);
        end
        chk("t3_en_size", 32'(en_w[2]), 0);

        // empty frame
        b0 = nfl[0]; f0 = nfd[0];
        str_len = 6'd0;
        pulse_refresh();
        wait_idle(50, "t4");
        step();
        chk("t4_flags", 32'(nfl[0] - b0), 0);
        chk("t4_frames", 32'(nfd[0] - f0), 1);
        chk("t4_done_delay", 32'(fd_cyc[0] - rcyc), 1);

        // two refreshes while busy queue exactly one more frame
        b0 = nfl[0]; f0 = nfd[0];
        str_len = 6'd4;
        pulse_refresh();
        repeat (4) step();
        pulse_refresh();
        repeat (3) step();
        pulse_refresh();
        wait_idle(1000, "t5");
        chk("t5_frames", 32'(nfd[0] - f0), 2);
        chk("t5_flags", 32'(nfl[0] - b0), 8);

        // init_done drop after the third flag
        b0 = nfl[0]; f0 = nfd[0];
        str_len = 6'd10;
        pulse_refresh();
        wait_flags(3, b0, "t6a");
        repeat (2) step();
        init_done = 1'b0;
        repeat (2) step();
        pulse_refresh();
        repeat (3) step();
        chk("t6a_busy", 32'(busy_w[0]), 0);
        init_done = 1'b1;
        repeat (20) step();
        chk("t6a_flags", 32'(nfl[0] - b0), 3);
        chk("t6a_frames", 32'(nfd[0] - f0), 0);
        chk("t6a_busy_late", 32'(busy_w[0]), 0);

        // asynchronous reset while waiting on the renderer
        b0 = nfl[0]; f0 = nfd[0];
        str_len = 6'd10;
        pulse_refresh();
        wait_flags(1, b0, "t6b");
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("t6b_flag", 32'(flag_w[d]), 0);
            chk("t6b_ascii", 32'(asc_w[d]), 0);
            chk("t6b_x", 32'(x_w[d]), 0);
            chk("t6b_y", 32'(y_w[d]), 0);
            chk("t6b_busy", 32'(busy_w[d]), 0);
            chk("t6b_frame_done", 32'(fd_w[d]), 0);
        end
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("t6b_flags", 32'(nfl[0] - b0), 1);
        chk("t6b_frames", 32'(nfd[0] - f0), 0);

        // randomized frames with stray done pulses, re-requests and init drops
        spur = 1;
        for (int it = 0; it < 25; it++) begin
            int n;
            for (int k = 0; k < 3; k++) wr($urandom_range(0, 31), 7'($urandom_range(0, 94)));
            dly = $urandom_range(1, 7);
            str_len = 6'($urandom_range(0, 40));
            pulse_refresh();
            n = 0;
            while (any_busy() && n < 3000) begin
                refresh = ($urandom_range(0, 24) == 0);
                if (init_done && $urandom_range(0, 99) == 0) init_done = 1'b0;
                else init_done = 1'b1;
                step();
                n++;
            end
            refresh = 1'b0;
            init_done = 1'b1;
            wait_idle(3000, "rnd");
        end
        spur = 0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/show_string_multi_ctrl.md
Name: show_string_multi_ctrl

Overview:
Parametrised successor to the fixed-string LCD text controller. It holds a writable character buffer of glyph codes (ASCII minus 32). On request, it draws the buffer as a multi-line text block with automatic line wrap. For each character it hands ascii_num, start_x and start_y to the downstream char renderer using the existing show_char_flag/show_char_done handshake. It sits between the UART/user logic and the LCD char-draw block.

Parameters:
MAX_CHARS, 32, buffer depth in characters (power of 2, minimum 2)
LINE_CHARS, 12, characters per row before wrap (minimum 1)
FONT16, 1, 1 selects 16x8 font (en_size=1); 0 selects 12x6 font
ORIGIN_X, 128, pixel x of the first character
ORIGIN_Y, 16, pixel y of the first row
COORD_W, 9, width of start_x and start_y

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous reset, active-high
init_done  in  1  LCD init complete; when low, no drawing occurs
show_char_done  in  1  renderer finished the current character (1-cycle pulse)
wr_en  in  1  buffer write strobe
wr_addr  in  $clog2(MAX_CHARS)  buffer write address
wr_data  in  7  glyph code to store
str_len  in  $clog2(MAX_CHARS)+1  number of characters to draw, sampled at frame start
refresh  in  1  1-cycle request to draw the frame
en_size  out  1  constant, equal to FONT16
show_char_flag  out  1  1-cycle pulse: start drawing the character
ascii_num  out  7  glyph code of the current character
start_x  out  COORD_W  pixel x of the current character
start_y  out  COORD_W  pixel y of the current character
busy  out  1  frame in progress
frame_done  out  1  1-cycle pulse after the last character, or immediately for an empty frame

Behaviour:
- Reset values: show_char_flag=0, ascii_num=0, start_x=0, start_y=0, busy=0, frame_done=0. Buffer contents are undefined after reset; every location must be written before use.
- Character geometry: CHAR_W is 8 when FONT16=1, otherwise 6. CHAR_H is 16 when FONT16=1, otherwise 12.
- For character index i: col = i mod LINE_CHARS, row = i / LINE_CHARS. Position uses incremental counters, with no divider or multiplier:
  - start_x = ORIGIN_X + col*CHAR_W
  - start_y = ORIGIN_Y + row*CHAR_H
  - Results are truncated to COORD_W bits. Wrap-around is the caller's responsibility.
- Buffer: 1 write port and 1 synchronous read port, with read latency of 1 cycle.
- Write vs read collision: a write to the address currently being read returns the old data.
- Writes are accepted in every state.
- State machine:
  - IDLE: on refresh && init_done, latch len=str_len, clear idx/col/row, set busy=1. If len==0, go to FIN; otherwise go to RD.
  - RD: issue the buffer read for idx, then go to ISSUE.
  - ISSUE: register ascii_num, start_x and start_y from the read data and counters. Pulse show_char_flag on the following cycle, with the outputs already stable. Then go to WAIT.
  - WAIT: hold ascii_num, start_x and start_y stable until show_char_done. On done: if idx==len-1, go to FIN; otherwise increment idx, advance col (col==LINE_CHARS-1 resets col to 0 and increments row), then go to RD.
  - FIN: pulse frame_done for 1 cycle, clear busy, go to IDLE.
- Latency: refresh to first show_char_flag is 3 cycles. Each show_char_done to the next show_char_flag is 3 cycles.
- refresh while busy: set a pending bit, ignore further repeats, and start a new frame on the cycle after FIN.
- refresh with init_done low: ignored, and no pending bit is set.
- init_done falling mid-frame: abort to IDLE next cycle. Clear busy and the pending bit. No frame_done, and no further flags.
- show_char_done outside WAIT: ignored.
- str_len > MAX_CHARS: clamp to MAX_CHARS.
- Reset mid-frame: all outputs return to their reset values asynchronously.

Decomposition:
- Package show_string_pkg: font constants (CHAR_W/CHAR_H for 16x8 and 12x6), the glyph code for blank (0), and the state encoding.
- Sub-module string_char_ram: simple dual-port MAX_CHARS x 7 RAM with 1-cycle registered read.

Test Plan:
1. Write "Hello World!" (40,69,76,76,79,0,55,79,82,76,68,1) to addresses 0-11, str_len=12, refresh, with a renderer model that returns done 5 cycles after each flag. Expect 12 flags; x = 128,136,...,216; y = 16 for all; codes match in order; 1 frame_done; busy low afterwards.
2. LINE_CHARS=4, str_len=6. Expect (x,y) = (128,16),(136,16),(144,16),(152,16),(128,32),(136,32).
3. FONT16=0, str_len=3. Expect en_size=0, x = 128,134,140, y = 16.
4. str_len=0, refresh. Expect no show_char_flag and frame_done exactly 1 cycle after refresh.
5. refresh pulsed twice during a frame. Expect exactly one additional full frame after the first frame_done.
6. Drop init_done after the 3rd flag; separately, assert sys_rst mid-WAIT. Expect no further flags, busy=0, no frame_done, and all outputs at 0 after reset.
